pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on posedge clk.
REQ-002 rst  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 id_rs0, id_rs1  in  4 each  source register addresses of the instruction in ID.
REQ-004 id_rs0_used, id_rs1_used  in  1 each  ID instruction reads rs0/rs1.
REQ-005 id_store  in  1  ID instruction is a store; rs1 is its store-data register.
REQ-006 ex_dst, ex_we, ex_mem_re  in  4/1/1  EX-stage destination, register write and load flag (the ID_EX outputs).
REQ-007 ex_br_taken, ex_hlt  in  1 each  branch resolved taken in EX; halt instruction is in EX.
REQ-008 stallIF, stallID, flushIF, flushID  out  1 each  hold or clear the IF_ID and ID_EX registers.
REQ-009 lwStall, memHazard  out  1 each  captured into ID_EX to select the load bypass or the store-data bypass.
REQ-010 halted  out  1  core fully drained and stopped.
REQ-011 state  out  3  current FSM state encoding, for debug.

Function
REQ-012 The FSM SHALL have the states RUN=0, LWSTALL=1, FLUSH=2, DRAIN=3 and HALT=4; all outputs SHALL be registered except the stall and flush strobes, which are decoded from state and inputs in the same cycle.
REQ-013 Load-use hazard, defined as ex_mem_re & ex_we & ex_dst!=0 & ((id_rs0_used & id_rs0==ex_dst) | (id_rs1_used & id_rs1==ex_dst & !id_store)), in RUN SHALL assert stallIF and stallID combinationally and enter LWSTALL.
REQ-014 In the LWSTALL state, lwStall SHALL be 1, and the FSM SHALL return to RUN after exactly 1 cycle; a load-use stall SHALL therefore never exceed 1 bubble.
REQ-015 Store-data-after-load, defined as id_store & ex_mem_re & id_rs1==ex_dst & ex_dst!=0, SHALL assert memHazard for that cycle with no stall.
REQ-016 In RUN, ex_br_taken SHALL assert flushIF and flushID combinationally for 1 cycle and enter FLUSH; FLUSH SHALL return to RUN after 1 cycle with no strobes asserted.
REQ-017 ex_br_taken SHALL take priority over a load-use hazard in the same cycle: flushes assert, stalls do not, and lwStall stays 0.
REQ-018 ex_hlt in RUN or FLUSH SHALL assert flushIF/flushID, hold stallIF, and enter DRAIN, where a 2-bit counter runs 3 cycles for the MEM and WB stages to retire.
REQ-019 ex_hlt SHALL take priority over ex_br_taken.
REQ-020 DRAIN SHALL move to HALT when the counter reaches 2; in HALT, halted=1, stallIF=stallID=1, and the FSM SHALL stay there until rst.
REQ-021 In DRAIN and HALT, the FSM SHALL ignore hazard and branch inputs.
REQ-022 Register address 0 SHALL never cause a hazard.

Reset
REQ-023 When rst=1, state SHALL be RUN, the counter 0, halted=0, lwStall=0, memHazard=0 and all strobes 0 on the following edge.
REQ-024 Reset asserted mid-stall, mid-flush or in DRAIN/HALT SHALL override all inputs.

Configuration
REQ-025 Macro HAZ_PERF_CNT_EN SHALL control performance counters.
- Defined: add outputs stall_cnt and flush_cnt (16 bits each, saturating at 0xFFFF), cleared by rst; they count cycles with stallID=1 in RUN/LWSTALL and cycles with flushID=1.
- Undefined: the ports and logic SHALL be absent.

Structure
REQ-026 The shared package SHALL hold the state encoding constants, REG_ZERO=4'd0 and DRAIN_CYCLES=2.
REQ-027 Hazard compare logic SHALL live in one sub-module, haz_detect (combinational: rs/dst compares to lu_hazard, st_hazard); the FSM and counters SHALL stay in pipe_hazard_ctrl.

Verification
REQ-028 Load-use: ex_mem_re=1, ex_we=1, ex_dst=3, id_rs0=3 used -> stallIF=stallID=1 for 1 cycle, state goes 0->1->0, lwStall=1 in the LWSTALL cycle.
REQ-029 Store after load: id_store=1, id_rs1=5, ex_dst=5 load, rs0 unrelated -> memHazard=1, no stall.
REQ-030 Branch plus load-use in the same cycle -> flushIF=flushID=1, stallID=0, state goes to 2 then 0.
REQ-031 Halt: ex_hlt=1 -> flush 1 cycle, DRAIN for 3 cycles, halted=1 on the 4th edge and held for 20 cycles despite ex_br_taken toggling.
REQ-032 Zero register: ex_dst=0 load, id_rs0=0 -> no stall.
REQ-033 Reset in DRAIN: rst=1 for 1 cycle -> state=0, halted=0, counters 0 (with HAZ_PERF_CNT_EN, stall_cnt=flush_cnt=0).

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and state encoding for the pipeline hazard controller.
// Optional HAZ_PERF_CNT_EN adds stall/flush performance counters in the top.
package pipe_hazard_ctrl_pkg;

  localparam logic [3:0] REG_ZERO     = 4'd0;
  localparam logic [1:0] DRAIN_CYCLES = 2'd2;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_LWSTALL = 3'd1,
    ST_FLUSH   = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_HALT    = 3'd4
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_haz_detect.sv
// Combinational register-address compares between the ID and EX stages.
module haz_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [3:0] id_rs0_i,
  input  logic [3:0] id_rs1_i,
  input  logic       id_rs0_used_i,
  input  logic       id_rs1_used_i,
  input  logic       id_store_i,
  input  logic [3:0] ex_dst_i,
  input  logic       ex_we_i,
  input  logic       ex_mem_re_i,
  output logic       lu_hazard_o,
  output logic       st_hazard_o
);

  logic dst_live;
  logic rs0_hit;
  logic rs1_hit;

  assign dst_live = ex_dst_i != REG_ZERO;
  assign rs0_hit  = id_rs0_used_i && (id_rs0_i == ex_dst_i);
  // Store data on rs1 is bypassed at MEM, so it must not trigger a stall.
  assign rs1_hit  = id_rs1_used_i && (id_rs1_i == ex_dst_i) && !id_store_i;

  assign lu_hazard_o = ex_mem_re_i && ex_we_i && dst_live && (rs0_hit || rs1_hit);
  assign st_hazard_o = id_store_i && ex_mem_re_i && dst_live && (id_rs1_i == ex_dst_i);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard FSM: load-use stall, branch flush, halt drain.
// Define HAZ_PERF_CNT_EN to add saturating stall_cnt/flush_cnt outputs.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] id_rs0,
  input  logic [3:0] id_rs1,
  input  logic       id_rs0_used,
  input  logic       id_rs1_used,
  input  logic       id_store,
  input  logic [3:0] ex_dst,
  input  logic       ex_we,
  input  logic       ex_mem_re,
  input  logic       ex_br_taken,
  input  logic       ex_hlt,
  output logic       stallIF,
  output logic       stallID,
  output logic       flushIF,
  output logic       flushID,
  output logic       lwStall,
  output logic       memHazard,
  output logic       halted,
  output logic [2:0] state
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       lwStall_q, memHazard_q, halted_q;
  logic       lu_hazard, st_hazard;
  logic       stall_if, stall_id, flush_if, flush_id;

  haz_detect u_haz_detect (
    .id_rs0_i      (id_rs0),
    .id_rs1_i      (id_rs1),
    .id_rs0_used_i (id_rs0_used),
    .id_rs1_used_i (id_rs1_used),
    .id_store_i    (id_store),
    .ex_dst_i      (ex_dst),
    .ex_we_i       (ex_we),
    .ex_mem_re_i   (ex_mem_re),
    .lu_hazard_o   (lu_hazard),
    .st_hazard_o   (st_hazard)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    stall_if = 1'b0;
    stall_id = 1'b0;
    flush_if = 1'b0;
    flush_id = 1'b0;
    unique case (state_q)
      ST_RUN, ST_FLUSH: begin
        if (ex_hlt) begin
          flush_if = 1'b1;
          flush_id = 1'b1;
          stall_if = 1'b1;
          state_d  = ST_DRAIN;
        end else if (state_q == ST_FLUSH) begin
          state_d = ST_RUN;
        end else if (ex_br_taken) begin
          flush_if = 1'b1;
          flush_id = 1'b1;
          state_d  = ST_FLUSH;
        end else if (lu_hazard) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          state_d  = ST_LWSTALL;
        end
      end
      ST_LWSTALL: state_d = ST_RUN;
      ST_DRAIN: begin
        stall_if = 1'b1;
        if (cnt_q == DRAIN_CYCLES) state_d = ST_HALT;
        else                       cnt_d   = cnt_q + 2'd1;
      end
      ST_HALT: begin
        stall_if = 1'b1;
        stall_id = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
    if (rst) begin
      state_d  = ST_RUN;
      cnt_d    = '0;
      stall_if = 1'b0;
      stall_id = 1'b0;
      flush_if = 1'b0;
      flush_id = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      lwStall_q   <= 1'b0;
      memHazard_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lwStall_q   <= state_d == ST_LWSTALL;
      memHazard_q <= st_hazard && (state_q == ST_RUN) && !ex_br_taken && !ex_hlt;
      halted_q    <= state_d == ST_HALT;
    end
  end

  assign stallIF   = stall_if;
  assign stallID   = stall_id;
  assign flushIF   = flush_if;
  assign flushID   = flush_id;
  assign lwStall   = lwStall_q;
  assign memHazard = memHazard_q;
  assign halted    = halted_q;
  assign state     = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_id && (state_q != ST_HALT) && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_id && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (HAZ_PERF_CNT_EN aware).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_rs0, id_rs1, ex_dst;
  logic       id_rs0_used, id_rs1_used, id_store, ex_we, ex_mem_re, ex_br_taken, ex_hlt;
  logic       stallIF, stallID, flushIF, flushID, lwStall, memHazard, halted;
  logic [2:0] state;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs0      (id_rs0),
    .id_rs1      (id_rs1),
    .id_rs0_used (id_rs0_used),
    .id_rs1_used (id_rs1_used),
    .id_store    (id_store),
    .ex_dst      (ex_dst),
    .ex_we       (ex_we),
    .ex_mem_re   (ex_mem_re),
    .ex_br_taken (ex_br_taken),
    .ex_hlt      (ex_hlt),
    .stallIF     (stallIF),
    .stallID     (stallID),
    .flushIF     (flushIF),
    .flushID     (flushID),
    .lwStall     (lwStall),
    .memHazard   (memHazard),
    .halted      (halted),
    .state       (state)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs0 = 4'd0; id_rs1 = 4'd0; id_rs0_used = 1'b0; id_rs1_used = 1'b0;
    id_store = 1'b0; ex_dst = 4'd0; ex_we = 1'b0; ex_mem_re = 1'b0;
    ex_br_taken = 1'b0; ex_hlt = 1'b0;
  endtask

  task automatic load_use_rs0(input logic [3:0] r);
    ex_mem_re = 1'b1; ex_we = 1'b1; ex_dst = r; id_rs0 = r; id_rs0_used = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    ex_br_taken = 1'b1;
    step();
    step();
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_halted", 16'(halted), 16'd0);
    chk("rst_lwstall", 16'(lwStall), 16'd0);
    chk("rst_memhaz", 16'(memHazard), 16'd0);
    chk("rst_flushid", 16'(flushID), 16'd0);
    chk("rst_stallif", 16'(stallIF), 16'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    chk("rst_flush_cnt", flush_cnt, 16'd0);
`endif
    rst = 1'b0;
    clear_inputs();
    step();

    // Load-use on rs0 = r3
    load_use_rs0(4'd3);
    #1;
    chk("lu_stallif", 16'(stallIF), 16'd1);
    chk("lu_stallid", 16'(stallID), 16'd1);
    chk("lu_flushid", 16'(flushID), 16'd0);
    chk("lu_state_run", 16'(state), 16'd0);
    step();
    clear_inputs();
    #1;
    chk("lu_state_lw", 16'(state), 16'd1);
    chk("lu_lwstall", 16'(lwStall), 16'd1);
    chk("lu_no_2nd_stall", 16'(stallID), 16'd0);
    step();
    chk("lu_state_back", 16'(state), 16'd0);
    chk("lu_lwstall_off", 16'(lwStall), 16'd0);

    // Store data after load: rs1 = r5 matches, rs0 unrelated
    id_store = 1'b1; id_rs1 = 4'd5; id_rs1_used = 1'b1; id_rs0 = 4'd2; id_rs0_used = 1'b1;
    ex_dst = 4'd5; ex_mem_re = 1'b1; ex_we = 1'b1;
    #1;
    chk("st_no_stallid", 16'(stallID), 16'd0);
    chk("st_no_stallif", 16'(stallIF), 16'd0);
    step();
    clear_inputs();
    chk("st_memhaz", 16'(memHazard), 16'd1);
    chk("st_state", 16'(state), 16'd0);
    step();
    chk("st_memhaz_off", 16'(memHazard), 16'd0);

    // Branch taken together with load-use: flush wins
    load_use_rs0(4'd3);
    ex_br_taken = 1'b1;
    #1;
    chk("br_flushif", 16'(flushIF), 16'd1);
    chk("br_flushid", 16'(flushID), 16'd1);
    chk("br_stallid", 16'(stallID), 16'd0);
    chk("br_stallif", 16'(stallIF), 16'd0);
    step();
    clear_inputs();
    #1;
    chk("br_state_flush", 16'(state), 16'd2);
    chk("br_lwstall", 16'(lwStall), 16'd0);
    chk("br_flush_quiet", 16'(flushID), 16'd0);
    step();
    chk("br_state_back", 16'(state), 16'd0);

    // Zero register never hazards
    load_use_rs0(4'd0);
    #1;
    chk("zero_stallid", 16'(stallID), 16'd0);
    chk("zero_stallif", 16'(stallIF), 16'd0);
    step();
    clear_inputs();
    chk("zero_state", 16'(state), 16'd0);

    // Halt (with a simultaneous branch): flush, 3 drain cycles, then HALT
    ex_hlt = 1'b1;
    ex_br_taken = 1'b1;
    #1;
    chk("hlt_flushif", 16'(flushIF), 16'd1);
    chk("hlt_flushid", 16'(flushID), 16'd1);
    chk("hlt_stallif", 16'(stallIF), 16'd1);
    step();
    clear_inputs();
    #1;
    chk("hlt_drain1", 16'(state), 16'd3);
    chk("hlt_drain_stallif", 16'(stallIF), 16'd1);
    chk("hlt_drain_noflush", 16'(flushID), 16'd0);
    step();
    chk("hlt_drain2", 16'(state), 16'd3);
    step();
    chk("hlt_drain3", 16'(state), 16'd3);
    chk("hlt_not_yet", 16'(halted), 16'd0);
    step();
    chk("hlt_state", 16'(state), 16'd4);
    chk("hlt_halted", 16'(halted), 16'd1);
    for (int i = 0; i < 20; i++) begin
      ex_br_taken = i[0];
      if (i[1]) load_use_rs0(4'd7);
      else begin ex_mem_re = 1'b0; ex_we = 1'b0; end
      #1;
      chk("hold_halted", 16'(halted), 16'd1);
      chk("hold_state", 16'(state), 16'd4);
      chk("hold_stallid", 16'(stallID), 16'd1);
      chk("hold_flushid", 16'(flushID), 16'd0);
      step();
    end
    clear_inputs();

    // Reset while in DRAIN
    rst = 1'b1;
    step();
    rst = 1'b0;
    ex_hlt = 1'b1;
    step();
    ex_hlt = 1'b0;
    chk("rd_in_drain", 16'(state), 16'd3);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rd_state", 16'(state), 16'd0);
    chk("rd_halted", 16'(halted), 16'd0);
    chk("rd_lwstall", 16'(lwStall), 16'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("rd_stall_cnt", stall_cnt, 16'd0);
    chk("rd_flush_cnt", flush_cnt, 16'd0);
`endif
    step();
    chk("rd_stays_run", 16'(state), 16'd0);

`ifdef HAZ_PERF_CNT_EN
    load_use_rs0(4'd4);
    step();
    clear_inputs();
    step();
    chk("pc_stall_cnt", stall_cnt, 16'd1);
    ex_br_taken = 1'b1;
    step();
    clear_inputs();
    step();
    chk("pc_flush_cnt", flush_cnt, 16'd1);
    chk("pc_stall_cnt_hold", stall_cnt, 16'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
